tmds_encoder: RTL



---
 rtl/tmds_encoder_pkg.sv | 18 +
 rtl/tmds_encoder_popcnt8.sv | 10 +
 rtl/tmds_encoder.sv | 88 ++++++++
 3 files changed

// File: rtl/tmds_encoder_pkg.sv
// tmds_encoder_pkg: TMDS character width, control tokens and bit-order helpers shared by encoder and decoder
package tmds_encoder_pkg;
  localparam int TMDS_CHAR_W = 10;
  typedef logic [TMDS_CHAR_W-1:0] tmds_char_t;
  localparam tmds_char_t CTL_TKN_00 = 10'b1101010100;
  localparam tmds_char_t CTL_TKN_01 = 10'b0010101011;
  localparam tmds_char_t CTL_TKN_10 = 10'b0101010100;
  localparam tmds_char_t CTL_TKN_11 = 10'b1010101011;
  function automatic tmds_char_t ctl_token(input logic [1:0] c);
    return c[1] ? (c[0] ? CTL_TKN_11 : CTL_TKN_10) : (c[0] ? CTL_TKN_01 : CTL_TKN_00);
  endfunction
  function automatic tmds_char_t bit_rev(input tmds_char_t x);
    tmds_char_t r;
    r = '0;
    for (int i = 0; i < TMDS_CHAR_W; i++) r[i] = x[TMDS_CHAR_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/tmds_encoder_popcnt8.sv
// tmds_popcnt8: combinational 8-bit population count (d_i in, n_o = number of ones 0..8)
module tmds_popcnt8 (
  input  logic [7:0] d_i,
  output logic [3:0] n_o
);
  always_comb begin
    n_o = '0;
    for (int i = 0; i < 8; i++) n_o = n_o + {3'b000, d_i[i]};
  end
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: 3-stage TMDS 8b/10b encoder (pixelclk/prst, pvde/pc0/pc1/pdata in; ptmds/pvde_o/pdisp out)
module tmds_encoder
  import tmds_encoder_pkg::*;
#(
  parameter bit kLsbFirst = 1'b1,
  parameter int kCntW     = 5
) (
  input  logic                    pixelclk,
  input  logic                    prst,
  input  logic                    pvde,
  input  logic                    pc0,
  input  logic                    pc1,
  input  logic [7:0]              pdata,
  output logic [TMDS_CHAR_W-1:0]  ptmds,
  output logic                    pvde_o,
  output logic signed [kCntW-1:0] pdisp
);
  localparam logic [kCntW-1:0] TWO = kCntW'(2);
  logic [7:0] d1_d, d1_q;
  logic [3:0] n1d_d, n1d_q, n1q_d, n1q_q;
  logic de1_q, de2_q, vde_q;
  logic [1:0] c1_q, c2_q;
  logic use_xnor, par, same_sign;
  logic [8:0] qm_d, qm_q;
  logic signed [kCntW-1:0] cnt_d, cnt_q, bal;
  tmds_char_t out_d, tmds_d, tmds_q;
  assign d1_d = pvde ? pdata : 8'h00;
  tmds_popcnt8 u_pc_d (.d_i(d1_d), .n_o(n1d_d));
  assign use_xnor = n1d_q > 4'd4 || (n1d_q == 4'd4 && !d1_q[0]);
  always_comb begin
    qm_d = {~use_xnor, 8'h00};
    par = 1'b0;
    for (int i = 0; i < 8; i++) begin
      par = par ^ d1_q[i];
      qm_d[i] = par ^ (use_xnor & i[0]);
    end
  end
  tmds_popcnt8 u_pc_q (.d_i(qm_d[7:0]), .n_o(n1q_d));
  assign bal = kCntW'({n1q_q, 1'b0}) - kCntW'(8);
  assign same_sign = cnt_q[kCntW-1] ? n1q_q < 4'd4 : n1q_q > 4'd4;
  always_comb begin
    out_d = ctl_token(c2_q);
    cnt_d = '0;
    if (de2_q) begin
      if (cnt_q == '0 || n1q_q == 4'd4) begin
        out_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? cnt_q + bal : cnt_q - bal;
      end else if (same_sign) begin
        out_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q - bal + (qm_q[8] ? TWO : '0);
      end else begin
        out_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q + bal - (qm_q[8] ? '0 : TWO);
      end
    end
  end
  assign tmds_d = kLsbFirst ? out_d : bit_rev(out_d);
  always_ff @(posedge pixelclk) begin
    if (prst) begin
      d1_q   <= '0;
      n1d_q  <= '0;
      de1_q  <= 1'b0;
      c1_q   <= '0;
      qm_q   <= '0;
      n1q_q  <= '0;
      de2_q  <= 1'b0;
      c2_q   <= '0;
      cnt_q  <= '0;
      tmds_q <= '0;
      vde_q  <= 1'b0;
    end else begin
      d1_q   <= d1_d;
      n1d_q  <= n1d_d;
      de1_q  <= pvde;
      c1_q   <= {pc1, pc0};
      qm_q   <= qm_d;
      n1q_q  <= n1q_d;
      de2_q  <= de1_q;
      c2_q   <= c1_q;
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
      vde_q  <= de2_q;
    end
  end
  assign ptmds  = tmds_q;
  assign pvde_o = vde_q;
  assign pdisp  = cnt_q;
endmodule
